// File: rtl/k_fetch_ctrl_if.sv
// Bundle between the K-constant fetch controller, its K ROM and the round engine.
// The master side is the controller; the slave side is the surrounding environment.
interface k_fetch_ctrl_if #(
  parameter int K_LENGTH = 64,
  parameter int AW       = $clog2(K_LENGTH)
);
  logic          start;
  logic          abort;
  logic          round_ready;
  logic [31:0]   k_data;
  logic          k_rd_en;
  logic [AW-1:0] k_address;
  logic          k_valid;
  logic [31:0]   k_value;
  logic          busy;
  logic          done;

  modport master (
    input  start, abort, round_ready, k_data,
    output k_rd_en, k_address, k_valid, k_value, busy, done
  );

  modport slave (
    output start, abort, round_ready, k_data,
    input  k_rd_en, k_address, k_valid, k_value, busy, done
  );
endinterface

// File: rtl/k_fetch_ctrl.sv
// Sequences the SHA-256 round constants out of a synchronous K ROM and hands
// each one to the round engine with a valid/ready handshake.
module k_fetch_ctrl #(
  parameter int K_LENGTH = 64
) (
  input  logic           clock,
  input  logic           reset,
  k_fetch_ctrl_if.master bus
);
  localparam int            AW       = $clog2(K_LENGTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(K_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    PRESENT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   value_q, value_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      value_q <= value_d;
    end
  end

  // ROM data arrives the cycle after the strobe, so it is captured in CAPTURE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    value_d = value_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        value_d = bus.k_data;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (bus.round_ready) begin
          if (addr_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
    // Abort overrides every transition above, including an accepted constant.
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
      addr_d  = '0;
    end
  end

  assign bus.k_rd_en   = (state_q == FETCH);
  assign bus.k_valid   = (state_q == PRESENT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.k_address = addr_q;
  assign bus.k_value   = value_q;
endmodule

// File: tb/tb_k_fetch_ctrl.sv
// Self-checking bench for k_fetch_ctrl: vector table, directed corner cases and
// a randomized run against a pass-level behavioural model.
module tb_k_fetch_ctrl;
  localparam int KL = 64;

  localparam logic [31:0] K [KL] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic        start;
    logic        abort;
    logic        rr;
    logic        rdEn;
    logic        valid;
    logic        busy;
    logic        done;
    logic [5:0]  addr;
    logic        chkVal;
    logic [31:0] val;
  } vec_t;

  logic clock;
  logic reset;
  int   testsRun;
  int   failures;

  k_fetch_ctrl_if bus ();

  k_fetch_ctrl #(.K_LENGTH(KL)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM: data is only meaningful the cycle after the strobe.
  always_ff @(posedge clock) begin
    if (bus.k_rd_en) bus.k_data <= K[bus.k_address];
    else             bus.k_data <= 32'hdead_beef;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    bus.start       = s;
    bus.abort       = a;
    bus.round_ready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] ctrlVec();
    return 64'({bus.k_rd_en, bus.k_valid, bus.busy, bus.done, bus.k_address});
  endfunction

  // Runs with round_ready=1 until index target is presented, checking the order.
  task automatic runTo(input int target, input bit noise);
    int expIdx = 0;
    int guard  = 0;
    while (!(bus.k_valid && int'(bus.k_address) == target) && guard < 1000) begin
      if (bus.k_valid) begin
        checkOutput($sformatf("order idx%0d", expIdx), {26'd0, bus.k_address, bus.k_value},
                    {26'd0, 6'(expIdx), K[expIdx]});
        expIdx++;
      end
      applyStimulus(noise ? 1'($urandom % 2) : 1'b0, 1'b0, 1'b1);
      guard++;
    end
    checkOutput($sformatf("reach idx%0d", target), 64'(guard < 1000), 64'd1);
  endtask

  initial begin
    vec_t vecs[14];
    int   cycles;
    int   seen;
    int   doneCnt;
    logic [31:0] lastVal;
    logic [5:0]  lastAddr;

    testsRun        = 0;
    failures        = 0;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.round_ready = 1'b0;

    vecs[0]  = '{1, 0, 0, 1, 0, 1, 0, 6'd0, 1, 32'd0};
    vecs[1]  = '{0, 0, 0, 0, 0, 1, 0, 6'd0, 1, 32'd0};
    vecs[2]  = '{0, 0, 0, 0, 1, 1, 0, 6'd0, 1, K[0]};
    vecs[3]  = '{0, 0, 0, 0, 1, 1, 0, 6'd0, 1, K[0]};
    vecs[4]  = '{0, 0, 1, 1, 0, 1, 0, 6'd1, 1, K[0]};
    vecs[5]  = '{1, 0, 0, 0, 0, 1, 0, 6'd1, 1, K[0]};
    vecs[6]  = '{0, 0, 0, 0, 1, 1, 0, 6'd1, 1, K[1]};
    vecs[7]  = '{0, 1, 1, 0, 0, 0, 0, 6'd0, 1, K[1]};
    vecs[8]  = '{1, 1, 0, 0, 0, 0, 0, 6'd0, 1, K[1]};
    vecs[9]  = '{1, 0, 0, 1, 0, 1, 0, 6'd0, 1, K[1]};
    vecs[10] = '{0, 1, 0, 0, 0, 0, 0, 6'd0, 1, K[1]};
    vecs[11] = '{1, 0, 0, 1, 0, 1, 0, 6'd0, 1, K[1]};
    vecs[12] = '{0, 0, 0, 0, 0, 1, 0, 6'd0, 1, K[1]};
    vecs[13] = '{0, 1, 0, 0, 0, 0, 0, 6'd0, 0, 32'd0};

    // Reset values.
    doReset();
    checkOutput("reset state", {ctrlVec()[31:0], bus.k_value}, 64'd0);

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].rr);
      checkOutput($sformatf("vec%0d", i),
                  {ctrlVec()[31:0], vecs[i].chkVal ? bus.k_value : 32'd0},
                  {22'd0, vecs[i].rdEn, vecs[i].valid, vecs[i].busy, vecs[i].done, vecs[i].addr,
                   vecs[i].chkVal ? vecs[i].val : 32'd0});
    end

    // First-fetch and first-present latency.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("latency fetch", 64'({bus.k_rd_en, bus.k_address}), 64'({1'b1, 6'd0}));
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("latency present", 64'({bus.k_valid, bus.k_value}), 64'({1'b1, 32'h428a2f98}));

    // Full pass with round_ready held high.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    cycles   = 1;
    seen     = 0;
    lastVal  = '0;
    lastAddr = '0;
    while (!bus.done && cycles < 400) begin
      if (bus.k_valid) begin
        checkOutput($sformatf("full idx%0d", seen), {26'd0, bus.k_address, bus.k_value},
                    {26'd0, 6'(seen), K[seen]});
        lastVal  = bus.k_value;
        lastAddr = bus.k_address;
        seen++;
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      cycles++;
    end
    checkOutput("full cycles", 64'(cycles), 64'(3 * KL + 1));
    checkOutput("full count", 64'(seen), 64'(KL));
    checkOutput("full last", {26'd0, lastAddr, lastVal}, {26'd0, 6'd63, 32'hc67178f2});
    doneCnt = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (bus.done) doneCnt++;
    end
    checkOutput("full after", 64'({bus.busy, 4'(doneCnt)}), 64'd0);

    // Stall while presenting index 7.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    runTo(7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("stall%0d", i), {ctrlVec()[31:0], bus.k_value}, {22'd0, 4'b0110, 6'd7, K[7]});
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("stall release", ctrlVec(), 64'({4'b1010, 6'd8}));
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stall next", {ctrlVec()[31:0], bus.k_value}, {22'd0, 4'b0110, 6'd8, K[8]});

    // Abort at index 20 beats round_ready, then a clean restart.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    runTo(20, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abort idle", ctrlVec(), 64'd0);
    doneCnt = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (bus.done || bus.busy) doneCnt++;
    end
    checkOutput("abort quiet", 64'(doneCnt), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("abort restart", ctrlVec(), 64'({4'b1010, 6'd0}));
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort restart val", {ctrlVec()[31:0], bus.k_value}, {22'd0, 4'b0110, 6'd0, K[0]});

    // Start noise mid-pass, then reset at index 40.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    runTo(40, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    checkOutput("reset midpass", {ctrlVec()[31:0], bus.k_value}, 64'd0);

    // Randomized run against a pass-level model.
    doReset();
    begin
      bit   active  = 1'b0;
      bit   doneNow = 1'b0;
      int   age     = 0;
      int   idx     = 0;
      int   passes  = 0;
      int   dones   = 0;
      logic s, a, r;
      logic [5:0] expAddr;
      for (int c = 0; c < 3000; c++) begin
        expAddr = active ? 6'(idx) : (doneNow ? 6'(KL - 1) : 6'd0);
        checkOutput($sformatf("rand c%0d", c), ctrlVec(),
                    64'({active && age == 0, active && age >= 2, active || doneNow, doneNow, expAddr}));
        if (active && age >= 2) checkOutput($sformatf("rand val c%0d", c), 64'(bus.k_value), 64'(K[idx]));
        if (doneNow) passes++;
        if (bus.done) dones++;
        s = 1'(($urandom % 8) == 0);
        a = 1'(($urandom % 200) == 0);
        r = 1'(($urandom % 3) != 0);
        if (doneNow) begin
          doneNow = 1'b0;
        end else if (active) begin
          if (a) begin
            active = 1'b0;
          end else if (age >= 2 && r) begin
            if (idx == KL - 1) begin
              active  = 1'b0;
              doneNow = 1'b1;
            end else begin
              idx++;
              age = 0;
            end
          end else if (age < 2) begin
            age++;
          end
        end else if (s && !a) begin
          active = 1'b1;
          idx    = 0;
          age    = 0;
        end
        applyStimulus(s, a, r);
      end
      checkOutput("rand passes", 64'(dones), 64'(passes));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end
endmodule
